// File: rtl/prf_writeback_arbiter.sv
// PRF write-port / CDB arbiter: three execution units (ALU, branch, LSU)
// each feed a small private FIFO, and a round-robin arbiter drains one
// queued result per cycle into registered PRF write and CDB broadcast outputs.
module prf_writeback_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 7,
    parameter int QUEUE_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic                  alu_wen,
    input  logic [ADDR_WIDTH-1:0] alu_paddr,
    input  logic [DATA_WIDTH-1:0] alu_data,

    input  logic                  br_valid,
    output logic                  br_ready,
    input  logic                  br_wen,
    input  logic [ADDR_WIDTH-1:0] br_paddr,
    input  logic [DATA_WIDTH-1:0] br_data,

    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic                  lsu_wen,
    input  logic [ADDR_WIDTH-1:0] lsu_paddr,
    input  logic [DATA_WIDTH-1:0] lsu_data,

    output logic                  prf_wen,
    output logic [ADDR_WIDTH-1:0] prf_waddr,
    output logic [DATA_WIDTH-1:0] prf_wdata,

    output logic                  cdb_valid,
    output logic [ADDR_WIDTH-1:0] cdb_tag,
    output logic [DATA_WIDTH-1:0] cdb_data
);

    localparam int NUM_SRC = 3;
    localparam int PTR_W   = $clog2(QUEUE_DEPTH);
    localparam int CNT_W   = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_BR  = 2'd1,
        SRC_LSU = 2'd2
    } src_e;

    // Source index reached by stepping 'offset' places round the ring from 'base'.
    function automatic int ringIndex(input int base, input int offset);
        int r;
        r = base + offset;
        if (r >= NUM_SRC) r = r - NUM_SRC;
        return r;
    endfunction

    // Source that follows 's' in the fixed ALU -> BR -> LSU -> ALU ring.
    function automatic src_e nextSrc(input src_e s);
        case (s)
            SRC_ALU: return SRC_BR;
            SRC_BR:  return SRC_LSU;
            default: return SRC_ALU;
        endcase
    endfunction

    logic                  srcValid [NUM_SRC];
    logic                  srcWen   [NUM_SRC];
    logic [ADDR_WIDTH-1:0] srcPaddr [NUM_SRC];
    logic [DATA_WIDTH-1:0] srcData  [NUM_SRC];
    logic                  srcReady [NUM_SRC];
    logic                  pushEn   [NUM_SRC];
    logic                  popEn    [NUM_SRC];

    logic [ADDR_WIDTH-1:0] qAddr_q [NUM_SRC][QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] qData_q [NUM_SRC][QUEUE_DEPTH];
    logic [PTR_W-1:0]      head_q  [NUM_SRC];
    logic [PTR_W-1:0]      head_d  [NUM_SRC];
    logic [PTR_W-1:0]      tail_q  [NUM_SRC];
    logic [PTR_W-1:0]      tail_d  [NUM_SRC];
    logic [CNT_W-1:0]      count_q [NUM_SRC];
    logic [CNT_W-1:0]      count_d [NUM_SRC];

    src_e                  rrPtr_q;
    src_e                  rrPtr_d;
    src_e                  grantSrc;
    logic                  grantValid;
    logic [ADDR_WIDTH-1:0] grantAddr;
    logic [DATA_WIDTH-1:0] grantData;

    logic                  prfWen_q;
    logic [ADDR_WIDTH-1:0] prfWaddr_q;
    logic [DATA_WIDTH-1:0] prfWdata_q;

    assign srcValid[0] = alu_valid;
    assign srcWen[0]   = alu_wen;
    assign srcPaddr[0] = alu_paddr;
    assign srcData[0]  = alu_data;
    assign srcValid[1] = br_valid;
    assign srcWen[1]   = br_wen;
    assign srcPaddr[1] = br_paddr;
    assign srcData[1]  = br_data;
    assign srcValid[2] = lsu_valid;
    assign srcWen[2]   = lsu_wen;
    assign srcPaddr[2] = lsu_paddr;
    assign srcData[2]  = lsu_data;

    // Ready comes from the registered count only, so a full queue stays not-ready even while it pops.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            srcReady[i] = (count_q[i] < DEPTH_C);
        end
    end

    assign alu_ready = srcReady[0];
    assign br_ready  = srcReady[1];
    assign lsu_ready = srcReady[2];

    // Round-robin pick: first non-empty queue scanning the ring from the pointer.
    always_comb begin
        grantValid = 1'b0;
        grantSrc   = rrPtr_q;
        grantAddr  = '0;
        grantData  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            int cand;
            cand = ringIndex(int'(rrPtr_q), k);
            if (!grantValid && (count_q[cand] != '0)) begin
                grantValid = 1'b1;
                grantSrc   = src_e'(cand[1:0]);
                grantAddr  = qAddr_q[cand][head_q[cand]];
                grantData  = qData_q[cand][head_q[cand]];
            end
        end
        rrPtr_d = grantValid ? nextSrc(grantSrc) : rrPtr_q;
    end

    // Queue bookkeeping: results without a destination, or aimed at P0, are accepted but dropped.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            pushEn[i]  = srcValid[i] && srcReady[i] && srcWen[i] && (srcPaddr[i] != '0);
            popEn[i]   = grantValid && (int'(grantSrc) == i);
            head_d[i]  = popEn[i]  ? head_q[i] + PTR_W'(1) : head_q[i];
            tail_d[i]  = pushEn[i] ? tail_q[i] + PTR_W'(1) : tail_q[i];
            count_d[i] = count_q[i];
            if (pushEn[i] && !popEn[i]) begin
                count_d[i] = count_q[i] + CNT_W'(1);
            end else if (popEn[i] && !pushEn[i]) begin
                count_d[i] = count_q[i] - CNT_W'(1);
            end
        end
    end

    // Queue pointers, occupancy and the round-robin pointer; reset empties every queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                head_q[i]  <= '0;
                tail_q[i]  <= '0;
                count_q[i] <= '0;
            end
            rrPtr_q <= SRC_ALU;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                head_q[i]  <= head_d[i];
                tail_q[i]  <= tail_d[i];
                count_q[i] <= count_d[i];
            end
            rrPtr_q <= rrPtr_d;
        end
    end

    // Queue storage needs no reset: entries are only read while the count says they are valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pushEn[i]) begin
                qAddr_q[i][tail_q[i]] <= srcPaddr[i];
                qData_q[i][tail_q[i]] <= srcData[i];
            end
        end
    end

    // Registered write/broadcast port: a grant loads the head entry, otherwise the enable drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prfWen_q   <= 1'b0;
            prfWaddr_q <= '0;
            prfWdata_q <= '0;
        end else begin
            prfWen_q <= grantValid;
            if (grantValid) begin
                prfWaddr_q <= grantAddr;
                prfWdata_q <= grantData;
            end
        end
    end

    assign prf_wen   = prfWen_q;
    assign prf_waddr = prfWaddr_q;
    assign prf_wdata = prfWdata_q;
    assign cdb_valid = prfWen_q;
    assign cdb_tag   = prfWaddr_q;
    assign cdb_data  = prfWdata_q;

endmodule

// File: tb/tb_prf_writeback_arbiter.sv
// Testbench for prf_writeback_arbiter: directed vector table, hand-written
// fairness and mid-operation reset sequences, and random traffic checked
// against a queue-based reference model.
module tb_prf_writeback_arbiter;

    localparam int DW = 32;
    localparam int AW = 7;
    localparam int QD = 2;

    logic          clk;
    logic          rst_n;
    logic          alu_valid, alu_ready, alu_wen;
    logic [AW-1:0] alu_paddr;
    logic [DW-1:0] alu_data;
    logic          br_valid, br_ready, br_wen;
    logic [AW-1:0] br_paddr;
    logic [DW-1:0] br_data;
    logic          lsu_valid, lsu_ready, lsu_wen;
    logic [AW-1:0] lsu_paddr;
    logic [DW-1:0] lsu_data;
    logic          prf_wen;
    logic [AW-1:0] prf_waddr;
    logic [DW-1:0] prf_wdata;
    logic          cdb_valid;
    logic [AW-1:0] cdb_tag;
    logic [DW-1:0] cdb_data;

    prf_writeback_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .QUEUE_DEPTH(QD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_wen   (alu_wen),
        .alu_paddr (alu_paddr),
        .alu_data  (alu_data),
        .br_valid  (br_valid),
        .br_ready  (br_ready),
        .br_wen    (br_wen),
        .br_paddr  (br_paddr),
        .br_data   (br_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_wen   (lsu_wen),
        .lsu_paddr (lsu_paddr),
        .lsu_data  (lsu_data),
        .prf_wen   (prf_wen),
        .prf_waddr (prf_waddr),
        .prf_wdata (prf_wdata),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Index 0 = ALU, 1 = BR, 2 = LSU in every per-source field.
    typedef struct packed {
        logic               doReset;
        logic [2:0]         valid;
        logic [2:0]         wen;
        logic [2:0][AW-1:0] paddr;
        logic [2:0][DW-1:0] data;
        logic [2:0]         expReady;
        logic               expWen;
        logic [AW-1:0]      expAddr;
        logic [DW-1:0]      expData;
    } vec_t;

    typedef logic [AW+DW-1:0] entry_t;

    int     vectors     = 0;
    int     miscompares = 0;
    vec_t   cur;
    vec_t   idle;
    entry_t mqAlu[$];
    entry_t mqBr[$];
    entry_t mqLsu[$];
    int     mPtr;
    logic          mExpWen;
    logic [AW-1:0] mExpAddr;
    logic [DW-1:0] mExpData;

    function automatic vec_t mk(input logic rs, input logic [2:0] vl, input logic [2:0] we,
                                input int p0, input int p1, input int p2,
                                input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                                input logic [2:0] er, input logic ew, input int ea, input logic [DW-1:0] ed);
        vec_t v;
        v          = '0;
        v.doReset  = rs;
        v.valid    = vl;
        v.wen      = we;
        v.paddr[0] = AW'(p0);
        v.paddr[1] = AW'(p1);
        v.paddr[2] = AW'(p2);
        v.data[0]  = d0;
        v.data[1]  = d1;
        v.data[2]  = d2;
        v.expReady = er;
        v.expWen   = ew;
        v.expAddr  = AW'(ea);
        v.expData  = ed;
        return v;
    endfunction

    // ---------------- reference model ----------------
    function automatic int qSize(input int s);
        case (s)
            0:       return mqAlu.size();
            1:       return mqBr.size();
            default: return mqLsu.size();
        endcase
    endfunction

    function automatic entry_t qPopFront(input int s);
        entry_t e;
        case (s)
            0:       e = mqAlu.pop_front();
            1:       e = mqBr.pop_front();
            default: e = mqLsu.pop_front();
        endcase
        return e;
    endfunction

    task automatic qPush(input int s, input entry_t e);
        case (s)
            0:       mqAlu.push_back(e);
            1:       mqBr.push_back(e);
            default: mqLsu.push_back(e);
        endcase
    endtask

    function automatic logic [2:0] modelReady();
        logic [2:0] r;
        for (int s = 0; s < 3; s++) r[s] = (qSize(s) < QD);
        return r;
    endfunction

    task automatic modelReset();
        mqAlu.delete();
        mqBr.delete();
        mqLsu.delete();
        mPtr    = 0;
        mExpWen = 1'b0;
    endtask

    // One clock edge: grant and readiness decided on the state before the edge.
    task automatic modelStep();
        logic [2:0] rdy;
        int         g;
        entry_t     e;
        rdy = modelReady();
        g   = -1;
        for (int k = 0; k < 3; k++) begin
            int c;
            c = (mPtr + k) % 3;
            if (g < 0 && qSize(c) > 0) g = c;
        end
        if (g >= 0) begin
            e        = qPopFront(g);
            mExpWen  = 1'b1;
            mExpAddr = e[AW+DW-1:DW];
            mExpData = e[DW-1:0];
            mPtr     = (g + 1) % 3;
        end else begin
            mExpWen = 1'b0;
        end
        for (int s = 0; s < 3; s++) begin
            if (cur.valid[s] && rdy[s] && cur.wen[s] && (cur.paddr[s] != '0))
                qPush(s, {cur.paddr[s], cur.data[s]});
        end
    endtask

    // ---------------- drive / check ----------------
    task automatic applyStimulus(input vec_t v);
        cur       = v;
        alu_valid = v.valid[0];
        alu_wen   = v.wen[0];
        alu_paddr = v.paddr[0];
        alu_data  = v.data[0];
        br_valid  = v.valid[1];
        br_wen    = v.wen[1];
        br_paddr  = v.paddr[1];
        br_data   = v.data[1];
        lsu_valid = v.valid[2];
        lsu_wen   = v.wen[2];
        lsu_paddr = v.paddr[2];
        lsu_data  = v.data[2];
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    // Called at posedge+1; drives, checks readies, crosses one edge, checks outputs.
    task automatic runCycle(input vec_t v, input bit useTable);
        logic [2:0]    er;
        logic          ew;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        applyStimulus(v);
        er = useTable ? v.expReady : modelReady();
        checkOutput("ready", {61'd0, lsu_ready, br_ready, alu_ready}, {61'd0, er});
        @(posedge clk);
        modelStep();
        #1;
        if (useTable) begin
            ew = v.expWen; ea = v.expAddr; ed = v.expData;
        end else begin
            ew = mExpWen; ea = mExpAddr; ed = mExpData;
        end
        checkOutput("prf_wen", 64'(prf_wen), 64'(ew));
        checkOutput("cdb_valid", 64'(cdb_valid), 64'(ew));
        if (ew) begin
            checkOutput("prf_waddr", 64'(prf_waddr), 64'(ea));
            checkOutput("prf_wdata", 64'(prf_wdata), 64'(ed));
            checkOutput("cdb_tag", 64'(cdb_tag), 64'(ea));
            checkOutput("cdb_data", 64'(cdb_data), 64'(ed));
        end
    endtask

    task automatic resetDut();
        applyStimulus(idle);
        rst_n = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_prf_wen"}, 64'(prf_wen), 64'd0);
        checkOutput({tag, "_prf_waddr"}, 64'(prf_waddr), 64'd0);
        checkOutput({tag, "_prf_wdata"}, 64'(prf_wdata), 64'd0);
        checkOutput({tag, "_cdb_valid"}, 64'(cdb_valid), 64'd0);
        checkOutput({tag, "_cdb_tag"}, 64'(cdb_tag), 64'd0);
        checkOutput({tag, "_cdb_data"}, 64'(cdb_data), 64'd0);
        checkOutput({tag, "_ready"}, {61'd0, lsu_ready, br_ready, alu_ready}, 64'd7);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    vec_t   tbl[21];
    int     wlog[$];

    initial begin
        int            accepted;
        int            nextAddr[3];
        int            expNext[3];
        logic [2:0]    rdy;
        vec_t          v;

        idle = '0;
        applyStimulus(idle);
        modelReset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checkResetState("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed table: single write, simultaneous push, pointer return, filtering, extremes, ring skip.
        tbl[0]  = mk(1, 3'b001, 3'b001,   5,  0,  0, 32'hDEADBEEF, 0, 0,            3'b111, 0,   0, 0);
        tbl[1]  = mk(0, 3'b000, 3'b000,   0,  0,  0, 0, 0, 0,                       3'b111, 1,   5, 32'hDEADBEEF);
        tbl[2]  = mk(0, 3'b000, 3'b000,   0,  0,  0, 0, 0, 0,                       3'b111, 0,   0, 0);
        tbl[3]  = mk(1, 3'b111, 3'b111,   1,  2,  3, 32'h11, 32'h22, 32'h33,        3'b111, 0,   0, 0);
        tbl[4]  = mk(0, 3'b000, 3'b000,   0,  0,  0, 0, 0, 0,                       3'b111, 1,   1, 32'h11);
        tbl[5]  = mk(0, 3'b000, 3'b000,   0,  0,  0, 0, 0, 0,                       3'b111, 1,   2, 32'h22);
        tbl[6]  = mk(0, 3'b000, 3'b000,   0,  0,  0, 0, 0, 0,                       3'b111, 1,   3, 32'h33);
        tbl[7]  = mk(0, 3'b000, 3'b000,   0,  0,  0, 0, 0, 0,                       3'b111, 0,   0, 0);
        tbl[8]  = mk(0, 3'b011, 3'b011,   6,  4,  0, 32'h66, 32'h44, 0,             3'b111, 0,   0, 0);
        tbl[9]  = mk(0, 3'b000, 3'b000,   0,  0,  0, 0, 0, 0,                       3'b111, 1,   6, 32'h66);
        tbl[10] = mk(0, 3'b000, 3'b000,   0,  0,  0, 0, 0, 0,                       3'b111, 1,   4, 32'h44);
        tbl[11] = mk(0, 3'b000, 3'b000,   0,  0,  0, 0, 0, 0,                       3'b111, 0,   0, 0);
        tbl[12] = mk(1, 3'b010, 3'b000,   0,  9,  0, 0, 32'h99, 0,                  3'b111, 0,   0, 0);
        tbl[13] = mk(0, 3'b100, 3'b100,   0,  0,  0, 0, 0, 32'h55,                  3'b111, 0,   0, 0);
        tbl[14] = mk(0, 3'b000, 3'b000,   0,  0,  0, 0, 0, 0,                       3'b111, 0,   0, 0);
        tbl[15] = mk(1, 3'b001, 3'b001, 127,  0,  0, 32'hFFFFFFFF, 0, 0,            3'b111, 0,   0, 0);
        tbl[16] = mk(0, 3'b000, 3'b000,   0,  0,  0, 0, 0, 0,                       3'b111, 1, 127, 32'hFFFFFFFF);
        tbl[17] = mk(0, 3'b000, 3'b000,   0,  0,  0, 0, 0, 0,                       3'b111, 0,   0, 0);
        tbl[18] = mk(0, 3'b001, 3'b001,  33,  0,  0, 32'h333, 0, 0,                 3'b111, 0,   0, 0);
        tbl[19] = mk(0, 3'b000, 3'b000,   0,  0,  0, 0, 0, 0,                       3'b111, 1,  33, 32'h333);
        tbl[20] = mk(0, 3'b000, 3'b000,   0,  0,  0, 0, 0, 0,                       3'b111, 0,   0, 0);

        for (int i = 0; i < 21; i++) begin
            if (tbl[i].doReset) resetDut();
            runCycle(tbl[i], 1'b1);
        end

        // Backpressure and fairness: all sources offer continuously for 12 cycles, then drain.
        resetDut();
        accepted    = 0;
        nextAddr[0] = 1;
        nextAddr[1] = 32;
        nextAddr[2] = 64;
        wlog.delete();
        for (int c = 0; c < 20; c++) begin
            v = '0;
            if (c < 12) begin
                v.valid = 3'b111;
                v.wen   = 3'b111;
                for (int s = 0; s < 3; s++) begin
                    v.paddr[s] = AW'(nextAddr[s]);
                    v.data[s]  = 32'hA500_0000 | 32'(nextAddr[s]);
                end
            end
            rdy = modelReady();
            runCycle(v, 1'b0);
            for (int s = 0; s < 3; s++) begin
                if (v.valid[s] && rdy[s]) begin
                    nextAddr[s]++;
                    accepted++;
                end
            end
            if (prf_wen) wlog.push_back(int'(prf_waddr));
        end
        checkOutput("fair_total_writes", 64'(wlog.size()), 64'(accepted));
        expNext[0] = 1;
        expNext[1] = 32;
        expNext[2] = 64;
        for (int i = 0; i < wlog.size(); i++) begin
            int src;
            src = (wlog[i] >= 64) ? 2 : (wlog[i] >= 32) ? 1 : 0;
            checkOutput("fair_interleave", 64'(src), 64'(i % 3));
            checkOutput("fifo_order", 64'(wlog[i]), 64'(expNext[src]));
            expNext[src]++;
        end

        // Mid-operation reset: fill queues, reset between edges, expect no stale writes.
        resetDut();
        v = mk(0, 3'b111, 3'b111, 10, 40, 70, 32'h10, 32'h40, 32'h70, 3'b111, 0, 0, 0);
        runCycle(v, 1'b0);
        v = mk(0, 3'b111, 3'b111, 11, 41, 71, 32'h11, 32'h41, 32'h71, 3'b111, 0, 0, 0);
        runCycle(v, 1'b0);
        applyStimulus(idle);
        rst_n = 1'b0;
        modelReset();
        #1;
        checkResetState("midreset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            runCycle(idle, 1'b0);
        end

        // Random traffic against the reference model, with one reset partway through.
        resetDut();
        for (int i = 0; i < 600; i++) begin
            if (i == 300) resetDut();
            v = '0;
            for (int s = 0; s < 3; s++) begin
                v.valid[s] = ($urandom_range(99) < 60);
                v.wen[s]   = ($urandom_range(99) < 85);
                v.paddr[s] = ($urandom_range(9) == 0) ? '0 : AW'($urandom_range(127));
                v.data[s]  = $urandom();
            end
            runCycle(v, 1'b0);
        end
        for (int c = 0; c < 8; c++) begin
            runCycle(idle, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/prf_writeback_arbiter.md
Name: prf_writeback_arbiter

Overview:
Shares the physical register file's single write port, and the matching CDB broadcast, among the three execution units: ALU, branch and LSU. Each unit pushes its results into a private 2-entry queue through a valid/ready handshake. A round-robin arbiter pops one queued result per cycle into registered write/broadcast outputs. Sits between the execution-unit result stages and the PRF write port (wen/waddr/wdata) plus the reservation-station wakeup bus.

Parameters:
DATA_WIDTH, 32, result data width
ADDR_WIDTH, 7, physical register index width (128 PRF entries)
QUEUE_DEPTH, 2, entries per source queue (power of two, >=2)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
alu_valid  input  1  ALU result offered
alu_ready  output  1  ALU queue can accept
alu_wen  input  1  result has a destination register
alu_paddr  input  ADDR_WIDTH  destination physical register
alu_data  input  DATA_WIDTH  result value
br_valid / br_ready / br_wen / br_paddr / br_data  same as ALU set  branch unit (JAL/JALR link writes)
lsu_valid / lsu_ready / lsu_wen / lsu_paddr / lsu_data  same as ALU set  LSU load results
prf_wen  output  1  PRF write enable
prf_waddr  output  ADDR_WIDTH  PRF write address
prf_wdata  output  DATA_WIDTH  PRF write data
cdb_valid  output  1  wakeup broadcast valid (equals prf_wen)
cdb_tag  output  ADDR_WIDTH  broadcast tag (equals prf_waddr)
cdb_data  output  DATA_WIDTH  broadcast value (equals prf_wdata)

Behaviour:
- Reset, asynchronous and immediate: all queues empty; round-robin pointer = ALU; prf_wen = cdb_valid = 0; prf_waddr = cdb_tag = 0; prf_wdata = cdb_data = 0. The *_ready outputs read 1 because the queues are empty.
- x_ready = (queue count < QUEUE_DEPTH). It depends only on registered count: no same-cycle pop bypass, so a full queue deasserts ready even in a cycle where it pops.
- Handshake: accept on valid & ready at a rising edge.
  - If x_wen = 0 or x_paddr = 0, the result is consumed but not enqueued. No write ever targets P0.
  - Data and paddr are sampled only at acceptance. Inputs are don't-care when valid = 0.
- Arbitration (combinational, on registered queue state): among non-empty queues, grant the first one found in the fixed ring ALU -> BR -> LSU -> ALU, starting at the pointer.
  - On a grant, pop that queue, load the output registers, and set the pointer to the source after the granted one.
  - With no grant, the pointer holds and prf_wen loads 0.
- Latency: result accepted at edge E0 -> earliest grant in the cycle after E0 -> outputs asserted for exactly one cycle after E1 -> PRF written at E2. Sustained throughput is 1 write per cycle across all sources.
- Registered outputs: prf_wen is high only in cycles following a grant. Back-to-back grants give a continuously high prf_wen.
- cdb_* outputs are identical copies of prf_*. Consumers must take the value from the CDB in the write cycle, because the PRF array updates only at the end of that cycle.
- Queue wrap-around: head and tail pointers wrap modulo QUEUE_DEPTH. Simultaneous push and pop on a non-full queue leaves the count unchanged, and FIFO order is preserved.
- Fairness: with all three queues continuously non-empty, each source receives exactly 1 of every 3 grants. No source waits more than 2 cycles once its queue reaches the head of arbitration.
- Reset asserted mid-operation: queued entries are discarded and prf_wen drops immediately. After rst_n rises, no stale write occurs.
- Duplicate paddr from two sources is not checked. Both are written, in grant order.

Test Plan:
- Reset: assert rst_n = 0 -> prf_wen = 0, prf_waddr = 0, prf_wdata = 0, cdb_valid = 0, alu_ready = br_ready = lsu_ready = 1.
- Single write: ALU pushes paddr = 5, data = 0xDEADBEEF at E0 -> cycle after E1 shows prf_wen = 1, prf_waddr = 5, prf_wdata = 0xDEADBEEF, cdb identical; prf_wen = 0 in the next cycle.
- Simultaneous: ALU/BR/LSU push paddr 1/2/3 (data 0x11/0x22/0x33) at the same edge, pointer = ALU -> three consecutive writes in order 1, 2, 3; pointer returns to ALU.
- Backpressure and fairness: all sources hold valid = 1 for 12 cycles with incrementing paddr -> alu_ready falls once its queue holds 2 entries. Write sequence interleaves ALU, BR, LSU strictly. No entry is lost or reordered within a source.
- Filtering: BR pushes wen = 0 with paddr = 9, then LSU pushes wen = 1 with paddr = 0 -> both are accepted (ready stays 1) and prf_wen never asserts.
- Mid-operation reset: fill all queues, pull rst_n low between edges -> prf_wen = 0 immediately. After release, with no new pushes, prf_wen stays 0 for 5 cycles.
